usensor_multi: RTL and testbench



---
 rtl/usensor_multi.sv | 197 +++++++++++++++++++
 tb/tb_usensor_multi.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usensor_multi.sv
// Round-robin multi-channel ultrasonic ranger: one sensor pings per slot and its echo
// width is converted to centimetres with a sub-cycle counter, with a per-channel timeout flag.
module usensor_multi #(
    parameter int NUM_CH         = 2,
    parameter int DIST_W         = 9,
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int SLOT_CYCLES    = 3_000_000
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           enable,
    input  logic [NUM_CH-1:0]                              echo,
    output logic [NUM_CH-1:0]                              trig,
    output logic [NUM_CH*DIST_W-1:0]                       distance,
    output logic [NUM_CH-1:0]                              timeout,
    output logic                                           valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] valid_ch
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = $clog2(SLOT_CYCLES + 1);
    localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_FIRE   = TMR_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TMR_W-1:0] SLOT_LAST = TMR_W'(SLOT_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [NUM_CH-1:0] echo_m;
    logic [NUM_CH-1:0] echo_s;
    logic [NUM_CH-1:0] echo_p;

    logic [CH_W-1:0]   ch;
    logic [TMR_W-1:0]  slot_timer;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [DIST_W-1:0] dist_r [NUM_CH];

    logic echo_sel;
    logic rise_sel;
    logic trig_done;
    logic timeout_hit;
    logic slot_done;

    logic clr_timer;
    logic start_meas;
    logic count_en;
    logic res_load;
    logic res_timeout;
    logic ch_adv;

    // Two-flop synchroniser plus one history stage for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_m <= '0;
            echo_s <= '0;
            echo_p <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_p <= echo_s;
        end
    end

    assign echo_sel  = echo_s[ch];
    assign rise_sel  = echo_s[ch] & ~echo_p[ch];
    assign trig_done = (slot_timer == TRIG_LAST);
    assign slot_done = (slot_timer == SLOT_LAST);
    // Decided one clock early so the registered strobe lands on slot_timer == TIMEOUT_CYCLES-1.
    assign timeout_hit = (slot_timer == TO_FIRE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (enable) state_nx = S_TRIG;
            end
            S_TRIG: begin
                if (trig_done) state_nx = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (timeout_hit)   state_nx = S_GAP;
                else if (rise_sel) state_nx = S_MEASURE;
            end
            S_MEASURE: begin
                if (timeout_hit || !echo_sel) state_nx = S_GAP;
            end
            S_GAP: begin
                if (slot_done) state_nx = enable ? S_TRIG : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        trig        = '0;
        clr_timer   = 1'b0;
        start_meas  = 1'b0;
        count_en    = 1'b0;
        res_load    = 1'b0;
        res_timeout = 1'b0;
        ch_adv      = 1'b0;
        case (state)
            S_IDLE: begin
                clr_timer = enable;
            end
            S_TRIG: begin
                trig[ch] = 1'b1;
            end
            S_WAIT_RISE: begin
                res_load    = timeout_hit;
                res_timeout = timeout_hit;
                start_meas  = rise_sel & ~timeout_hit;
            end
            S_MEASURE: begin
                res_load    = timeout_hit | ~echo_sel;
                res_timeout = timeout_hit;
                count_en    = echo_sel & ~timeout_hit;
            end
            S_GAP: begin
                ch_adv    = slot_done;
                clr_timer = slot_done & enable;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_timer <= '0;
            sub_cnt    <= '0;
            cm_cnt     <= '0;
            ch         <= '0;
            valid      <= 1'b0;
            valid_ch   <= '0;
            timeout    <= '0;
            dist_r     <= '{default: '0};
        end else begin
            valid <= res_load;

            if (clr_timer) begin
                slot_timer <= '0;
            end else if (state != S_IDLE) begin
                slot_timer <= slot_timer + 1'b1;
            end

            if (start_meas) begin
                sub_cnt <= '0;
                cm_cnt  <= '0;
            end else if (count_en) begin
                if (sub_cnt == SUB_LAST) begin
                    sub_cnt <= '0;
                    if (cm_cnt != '1) cm_cnt <= cm_cnt + 1'b1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            if (res_load) begin
                valid_ch    <= ch;
                timeout[ch] <= res_timeout;
                dist_r[ch]  <= res_timeout ? '1 : cm_cnt;
            end

            if (ch_adv) begin
                ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dist
        assign distance[k*DIST_W +: DIST_W] = dist_r[k];
    end

endmodule

// File: tb/tb_usensor_multi.sv
// Scenario bench for usensor_multi: slot timing, echo-width conversion, timeouts,
// enable handling and resets, against a width/CYCLES_PER_CM reference model.
module tb_usensor_multi;

    localparam int NUM_CH         = 2;
    localparam int DIST_W         = 5;
    localparam int TRIG_CYCLES    = 5;
    localparam int CYCLES_PER_CM  = 10;
    localparam int TIMEOUT_CYCLES = 400;
    localparam int SLOT_CYCLES    = 600;
    localparam int DMAX           = (1 << DIST_W) - 1;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NUM_CH-1:0]        echo;
    logic [NUM_CH-1:0]        trig;
    logic [NUM_CH*DIST_W-1:0] distance;
    logic [NUM_CH-1:0]        timeout;
    logic                     valid;
    logic [0:0]               valid_ch;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int exp_dist [NUM_CH];
    bit exp_to   [NUM_CH];

    usensor_multi #(
        .NUM_CH(NUM_CH),
        .DIST_W(DIST_W),
        .TRIG_CYCLES(TRIG_CYCLES),
        .CYCLES_PER_CM(CYCLES_PER_CM),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SLOT_CYCLES(SLOT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .echo(echo),
        .trig(trig),
        .distance(distance),
        .timeout(timeout),
        .valid(valid),
        .valid_ch(valid_ch)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: whole centimetres of echo width, clamped to the distance range.
    function automatic int model_cm(input int width);
        int cm;
        cm = width / CYCLES_PER_CM;
        return (cm > DMAX) ? DMAX : cm;
    endfunction

    function automatic int dget(input int c);
        return int'(distance[c*DIST_W +: DIST_W]);
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_trig_rise(input int k, input int budget, output int n);
        n = 0;
        while (trig[k] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (trig[k] !== 1'b1) n = -1;
    endtask

    task automatic wait_trig_fall(input int k, input int budget, output int n);
        n = 0;
        while (trig[k] === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (trig[k] === 1'b1) n = -1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        forever begin
            tick();
            n++;
            if (valid === 1'b1) break;
            if (n >= budget) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic echo_pulse(input int k, input int d, input int w, input bit noise);
        repeat (d) tick();
        echo[k] = 1'b1;
        repeat (w) begin
            tick();
            if (noise) echo[1-k] = 1'($urandom);
        end
        echo[k]   = 1'b0;
        echo[1-k] = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        reset  = 1'b1;
        enable = 1'b1;
        echo   = '0;
        repeat (3) tick();
        checks++;
        if (trig !== 2'b00 || distance !== '0 || timeout !== 2'b00 || valid !== 1'b0 || valid_ch !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: trig %b dist %h to %b valid %b vch %b want all zero",
                     trig, distance, timeout, valid, valid_ch);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (trig !== 2'b01) begin
            errors++;
            $display("FAIL first_trig: trig %b want 01", trig);
        end
        last_rise = cyc;
        w = 0;
        while (trig[0] === 1'b1 && w < 20) begin
            w++;
            tick();
        end
        checks++;
        if (w !== TRIG_CYCLES) begin
            errors++;
            $display("FAIL trig_width: got %0d want %0d", w, TRIG_CYCLES);
        end
        checks++;
        if (distance !== '0 || timeout !== 2'b00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_result_zero: dist %h to %b valid %b want zero", distance, timeout, valid);
        end
    endtask

    task automatic test_measure_ch0();
        int n;
        wait_trig_fall(0, 20, n);
        echo_pulse(0, 20, 105, 1'b0);
        wait_valid(10, n);
        checks++;
        if (n !== 3 || valid_ch !== 1'b0) begin
            errors++;
            $display("FAIL m0_latency: latency %0d ch %0d want 3 ch 0", n, valid_ch);
        end
        exp_dist[0] = model_cm(105);
        exp_to[0]   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (dget(c) !== exp_dist[c] || timeout[c] !== exp_to[c]) begin
                errors++;
                $display("FAIL m0_result ch%0d: dist %0d to %b want dist %0d to %b",
                         c, dget(c), timeout[c], exp_dist[c], exp_to[c]);
            end
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL m0_valid_width: valid %b want 0", valid);
        end
    endtask

    task automatic test_timeout_ch1();
        int n;
        int early;
        int total;
        wait_trig_rise(1, 700, n);
        checks++;
        if (n < 0 || cyc - last_rise !== SLOT_CYCLES) begin
            errors++;
            $display("FAIL ch1_rise_spacing: got %0d want %0d", (n < 0) ? -1 : cyc - last_rise, SLOT_CYCLES);
        end
        last_rise = cyc;
        early = 0;
        repeat (100) begin
            tick();
            echo[0] = 1'($urandom);
            if (valid === 1'b1) early++;
        end
        echo[0] = 1'b0;
        wait_valid(400, n);
        total = (n < 0 || early != 0) ? -1 : 100 + n;
        checks++;
        if (total !== TIMEOUT_CYCLES - 1 || valid_ch !== 1'b1) begin
            errors++;
            $display("FAIL to1_latency: latency %0d ch %0d want %0d ch 1", total, valid_ch, TIMEOUT_CYCLES - 1);
        end
        exp_dist[1] = DMAX;
        exp_to[1]   = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (dget(c) !== exp_dist[c] || timeout[c] !== exp_to[c]) begin
                errors++;
                $display("FAIL to1_result ch%0d: dist %0d to %b want dist %0d to %b",
                         c, dget(c), timeout[c], exp_dist[c], exp_to[c]);
            end
        end
    endtask

    task automatic test_saturation_ch0();
        int n;
        wait_trig_rise(0, 700, n);
        checks++;
        if (n < 0 || cyc - last_rise !== SLOT_CYCLES) begin
            errors++;
            $display("FAIL ch0_rise_spacing: got %0d want %0d", (n < 0) ? -1 : cyc - last_rise, SLOT_CYCLES);
        end
        last_rise = cyc;
        wait_trig_fall(0, 20, n);
        echo_pulse(0, 20, 350, 1'b0);
        wait_valid(10, n);
        checks++;
        if (n !== 3 || valid_ch !== 1'b0) begin
            errors++;
            $display("FAIL sat_latency: latency %0d ch %0d want 3 ch 0", n, valid_ch);
        end
        exp_dist[0] = model_cm(350);
        exp_to[0]   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (dget(c) !== exp_dist[c] || timeout[c] !== exp_to[c]) begin
                errors++;
                $display("FAIL sat_result ch%0d: dist %0d to %b want dist %0d to %b",
                         c, dget(c), timeout[c], exp_dist[c], exp_to[c]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int k;
        int d;
        int w;
        for (int i = 0; i < 6; i++) begin
            k = (i + 1) % NUM_CH;
            d = $urandom_range(60, 2);
            // Keep the width away from whole-cm boundaries so the +-1 clock tolerance cannot matter.
            w = CYCLES_PER_CM * $urandom_range(29, 1) + $urandom_range(9, 2);
            wait_trig_rise(k, 700, n);
            checks++;
            if (n < 0 || cyc - last_rise !== SLOT_CYCLES) begin
                errors++;
                $display("FAIL rnd%0d_rise_spacing: got %0d want %0d", i, (n < 0) ? -1 : cyc - last_rise, SLOT_CYCLES);
            end
            last_rise = cyc;
            wait_trig_fall(k, 20, n);
            echo_pulse(k, d, w, 1'b1);
            wait_valid(10, n);
            checks++;
            if (n !== 3 || valid_ch !== 1'(k)) begin
                errors++;
                $display("FAIL rnd%0d_latency: latency %0d ch %0d want 3 ch %0d", i, n, valid_ch, k);
            end
            exp_dist[k] = model_cm(w);
            exp_to[k]   = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (dget(c) !== exp_dist[c] || timeout[c] !== exp_to[c]) begin
                    errors++;
                    $display("FAIL rnd%0d_result ch%0d w%0d: dist %0d to %b want dist %0d to %b",
                             i, c, w, dget(c), timeout[c], exp_dist[c], exp_to[c]);
                end
            end
        end
    endtask

    task automatic test_stuck_high_ch1();
        int n;
        echo[1] = 1'b1;
        wait_trig_rise(1, 700, n);
        checks++;
        if (n < 0 || cyc - last_rise !== SLOT_CYCLES) begin
            errors++;
            $display("FAIL stuck_rise_spacing: got %0d want %0d", (n < 0) ? -1 : cyc - last_rise, SLOT_CYCLES);
        end
        last_rise = cyc;
        wait_valid(500, n);
        checks++;
        if (n !== TIMEOUT_CYCLES - 1 || valid_ch !== 1'b1) begin
            errors++;
            $display("FAIL stuck_latency: latency %0d ch %0d want %0d ch 1", n, valid_ch, TIMEOUT_CYCLES - 1);
        end
        exp_dist[1] = DMAX;
        exp_to[1]   = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (dget(c) !== exp_dist[c] || timeout[c] !== exp_to[c]) begin
                errors++;
                $display("FAIL stuck_result ch%0d: dist %0d to %b want dist %0d to %b",
                         c, dget(c), timeout[c], exp_dist[c], exp_to[c]);
            end
        end
        echo[1] = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n;
        int trig_hi;
        int extra_valid;
        wait_trig_rise(0, 700, n);
        checks++;
        if (n < 0 || cyc - last_rise !== SLOT_CYCLES) begin
            errors++;
            $display("FAIL en_rise_spacing: got %0d want %0d", (n < 0) ? -1 : cyc - last_rise, SLOT_CYCLES);
        end
        wait_trig_fall(0, 20, n);
        repeat (20) tick();
        echo[0] = 1'b1;
        repeat (10) tick();
        enable = 1'b0;
        repeat (45) tick();
        echo[0] = 1'b0;
        wait_valid(10, n);
        checks++;
        if (n !== 3 || valid_ch !== 1'b0) begin
            errors++;
            $display("FAIL en_latency: latency %0d ch %0d want 3 ch 0", n, valid_ch);
        end
        exp_dist[0] = model_cm(55);
        exp_to[0]   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (dget(c) !== exp_dist[c] || timeout[c] !== exp_to[c]) begin
                errors++;
                $display("FAIL en_result ch%0d: dist %0d to %b want dist %0d to %b",
                         c, dget(c), timeout[c], exp_dist[c], exp_to[c]);
            end
        end
        trig_hi     = 0;
        extra_valid = 0;
        repeat (800) begin
            tick();
            if (trig !== 2'b00) trig_hi++;
            if (valid === 1'b1) extra_valid++;
        end
        checks++;
        if (trig_hi !== 0 || extra_valid !== 0) begin
            errors++;
            $display("FAIL en_idle: trig-high clocks %0d valids %0d want 0 and 0", trig_hi, extra_valid);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (trig !== 2'b10) begin
            errors++;
            $display("FAIL en_resume: trig %b want 10", trig);
        end
        last_rise = cyc;
    endtask

    task automatic test_reset_mid();
        int n;
        int v;
        wait_trig_fall(1, 20, n);
        repeat (20) tick();
        echo[1] = 1'b1;
        repeat (30) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (trig !== 2'b00 || distance !== '0 || timeout !== 2'b00 || valid !== 1'b0 || valid_ch !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: trig %b dist %h to %b valid %b vch %b want all zero",
                     trig, distance, timeout, valid, valid_ch);
        end
        v = 0;
        repeat (2) begin
            tick();
            if (valid === 1'b1) v++;
        end
        echo  = '0;
        reset = 1'b0;
        tick();
        if (valid === 1'b1) v++;
        checks++;
        if (trig !== 2'b01 || v !== 0) begin
            errors++;
            $display("FAIL rst_mid_restart: trig %b valids %0d want 01 and 0", trig, v);
        end
        tick();
        #2;
        checks++;
        if (trig !== 2'b01) begin
            errors++;
            $display("FAIL rst_trig_pre: trig %b want 01", trig);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (trig !== 2'b00) begin
            errors++;
            $display("FAIL rst_async_trig: trig %b want 00", trig);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        echo   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_dist[c] = 0;
            exp_to[c]   = 1'b0;
        end
        test_reset();
        test_measure_ch0();
        test_timeout_ch1();
        test_saturation_ch0();
        test_random();
        test_stuck_high_ch1();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
